mux_select_stage: RTL
=====================

MUX_SELECT_STAGE -- requirements
Module: mux_select_stage

Interface
REQ-001 Parameter WIDTH, default 5, bit width of each data channel and of the output.
REQ-002 Parameter NUM_IN, default 3, number of input channels (legal range 2..16).
REQ-003 Parameter SEL_W, default 2, width of the select field (SHALL satisfy 2**SEL_W >= NUM_IN).
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 InData  input  WIDTH*NUM_IN  packed channels; channel i at bits [i*WIDTH +: WIDTH].
REQ-007 Signal  input  SEL_W  channel select, sampled with InValid.
REQ-008 InValid  input  1  producer offers InData/Signal this cycle.
REQ-009 InReady  output  1  stage can accept a transfer this cycle.
REQ-010 Flush  input  1  synchronous discard of all buffered entries.
REQ-011 Out  output  WIDTH  selected data at head of buffer.
REQ-012 OutValid  output  1  Out holds a valid entry.
REQ-013 OutReady  input  1  consumer accepts head entry this cycle.
REQ-014 SelErr  output  1  sticky out-of-range-select flag (only with SEL_ERR_EN).

Function
REQ-015 Transfer in occurs when InValid and InReady are both 1 at a rising edge; selected channel InData[Signal] is written to a 2-entry FIFO.
REQ-016 Signal >= NUM_IN SHALL store all-zero data (still accepted, still counted as one entry).
REQ-017 Transfer out occurs when OutValid and OutReady are both 1; head entry is popped.
REQ-018 InReady SHALL be driven only from registered occupancy: 1 when count < 2, independent of OutReady in the same cycle.
REQ-019 Latency: accepted entry into empty buffer appears on Out with OutValid=1 on the next cycle; no combinational path from InData to Out.
REQ-020 Occupancy count 0..2; push-only +1, pop-only -1, push and pop same cycle (count=1) leaves count 1 and Out becomes the new entry.
REQ-021 Count=2: InReady=0, InValid ignored; count=0: OutValid=0, OutReady ignored.
REQ-022 Entries SHALL leave in acceptance order; Out and OutValid SHALL stay stable while OutValid=1 and OutReady=0.
REQ-023 Flush=1 SHALL set count to 0 next cycle and ignore any push/pop in that cycle; OutValid=0 the following cycle.
REQ-024 Out SHALL read all-zero whenever OutValid=0.

Reset
REQ-025 Reset=1 SHALL immediately (without clock) set count=0, OutValid=0, Out=0, InReady=1, SelErr=0.
REQ-026 Reset asserted mid-transfer SHALL discard all buffered entries; first legal push is on the first rising edge after Reset deasserts.

Configuration
REQ-027 Macro SEL_ERR_EN defined: SelErr sets on the first accepted transfer with Signal >= NUM_IN and holds until Reset (Flush does not clear it).
REQ-028 Macro SEL_ERR_EN undefined: SelErr port SHALL be tied to 0 and no error register synthesised; data behaviour per REQ-016 is unchanged.

Verification
REQ-029 Defaults, InData channels {9,7,5} (ch0=5), Signal 0,1,2 pushed with OutReady=1 -> Out 5,7,9 on consecutive cycles, each one cycle after acceptance.
REQ-030 Signal=3 pushed -> Out=0, OutValid=1; SelErr=1 with SEL_ERR_EN, SelErr=0 without.
REQ-031 OutReady=0, push 5 then 7 -> InReady=0 after second push; third push (9) ignored; then OutReady=1 -> Out 5, then 7, then OutValid=0.
REQ-032 Count=1 holding 5, push 7 with OutReady=1 same cycle -> next cycle Out=7, count stays 1, InReady=1.
REQ-033 Count=2, Flush=1 with InValid=1 -> next cycle OutValid=0, InReady=1, pushed value absent.
REQ-034 Reset pulsed between clock edges while count=2 -> OutValid=0, Out=0, InReady=1 before next edge; WIDTH=8, NUM_IN=4 rerun of REQ-029 with Signal=3 returns channel 3 data.

Source files
------------

// File: rtl/mux_select_stage.sv
// Registered channel-select stage: picks InData[Signal] and buffers it in a 2-entry FIFO.
// Optional sticky out-of-range select flag on SelErr when SEL_ERR_EN is defined.
module mux_select_stage #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [WIDTH*NUM_IN-1:0] InData,
  input  logic [SEL_W-1:0]        Signal,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic                    Flush,
  output logic [WIDTH-1:0]        Out,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic                    SelErr
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr, wr_ptr;
  logic             push, pop;
  logic [WIDTH-1:0] sel_data;

  // Out-of-range selects fall through with the all-zero default.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (32'(Signal) == i) begin
        sel_data = InData[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    InReady   = 1'b0;
    OutValid  = 1'b0;
    case (state)
      EMPTY: InReady = 1'b1;
      ONE: begin
        InReady  = 1'b1;
        OutValid = 1'b1;
      end
      FULL: OutValid = 1'b1;
      default: InReady = 1'b1;
    endcase

    push = InValid && InReady && !Flush;
    pop  = OutValid && OutReady && !Flush;

    if (Flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (push) state_nxt = ONE;
        ONE: begin
          if (push && !pop) state_nxt = FULL;
          else if (pop && !push) state_nxt = EMPTY;
        end
        FULL: if (pop) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (Flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wr_ptr] <= sel_data;
    end
  end

  assign Out = OutValid ? mem[rd_ptr] : '0;

`ifdef SEL_ERR_EN
  logic sel_bad;
  logic sel_err_q;

  assign sel_bad = 32'(Signal) >= 32'(NUM_IN);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sel_err_q <= 1'b0;
    end else if (push && sel_bad) begin
      sel_err_q <= 1'b1;
    end
  end

  assign SelErr = sel_err_q;
`else
  assign SelErr = 1'b0;
`endif

endmodule
